// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - screen/game constants and game-state enum shared by the flappy controllers
package flappy_pkg;

   localparam logic [10:0] H_VIS_START = 11'd144;
   localparam logic [10:0] H_VIS_END   = 11'd783;
   localparam logic [10:0] V_VIS_START = 11'd35;
   localparam logic [10:0] V_VIS_END   = 11'd514;

   localparam logic [10:0] EXIT_X      = 11'd104;
   localparam logic [10:0] WRAP_DIST   = 11'd680;
   localparam logic [9:0]  GAP_MIN     = 10'd75;

   typedef enum logic [1:0] {IDLE, RUN, DEAD} game_state_t;

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded on reset
module lfsr8 #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [7:0] out
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         out <= SEED;
      else if (en)
         out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
   end

endmodule

// File: rtl/pipe_controller.sv
// rtl/pipe_controller.sv - two scrolling pipes, bird collision, score and game-state FSM
module pipe_controller
   import flappy_pkg::*;
#(
   parameter int PIPE_W = 40,
   parameter int GAP_H  = 120,
   parameter int SPEED  = 2,
   parameter int BIRD_X = 450
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       up,
   input  logic [9:0] bird_y,
   input  logic [9:0] hCount,
   input  logic [9:0] vCount,
   output logic       pipe_fill,
   output logic       game_over,
   output logic [7:0] score
);

   localparam logic [10:0] PW    = 11'(PIPE_W);
   localparam logic [10:0] GH    = 11'(GAP_H);
   localparam logic [10:0] SP    = 11'(SPEED);
   localparam logic [10:0] BOX_L = 11'(BIRD_X - 5);
   localparam logic [10:0] BOX_R = 11'(BIRD_X + 5);

   game_state_t state, state_nxt;
   logic [7:0]  lfsr_out;
   logic [10:0] px [2];
   logic [9:0]  gap_top [2];
   logic [1:0]  hit, fill, pass;
   logic        ground, collide, scroll;
   logic [10:0] h11, v11, by11;
   logic [8:0]  score_sum;

   assign h11  = {1'b0, hCount};
   assign v11  = {1'b0, vCount};
   assign by11 = {1'b0, bird_y};

   lfsr8 #(.SEED(8'hA5)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .out (lfsr_out)
   );

   for (genvar i = 0; i < 2; i++) begin : g_pipe
      localparam logic [10:0] PX_RST  = (i == 0) ? 11'd784 : 11'd1124;
      localparam logic [9:0]  GAP_RST = (i == 0) ? 10'd200 : 10'd150;

      logic [10:0] px_q, px_nxt, gt, gb, right_edge;
      logic [9:0]  gap_q;
      logic        wrap;

      assign px[i]      = px_q;
      assign gap_top[i] = gap_q;
      assign gt         = {1'b0, gap_q};
      assign gb         = gt + GH;
      assign right_edge = px_q + PW - 11'd1;
      assign wrap       = (px_q <= EXIT_X);
      assign px_nxt     = wrap ? px_q + WRAP_DIST - SP : px_q - SP;

      // bird_y-5 < gap_top is rewritten as bird_y < gap_top+5 to avoid underflow near the top
      assign hit[i]  = (px_q <= BOX_R) && (right_edge >= BOX_L) &&
                       ((by11 < gt + 11'd5) || (by11 + 11'd5 >= gb));
      assign pass[i] = (right_edge >= BOX_L) && (px_nxt + PW - 11'd1 < BOX_L);
      assign fill[i] = (h11 >= px_q) && (h11 < px_q + PW) &&
                       (v11 >= V_VIS_START) && (v11 <= V_VIS_END) &&
                       ((v11 < gt) || (v11 >= gb));

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            px_q  <= PX_RST;
            gap_q <= GAP_RST;
         end else if (scroll) begin
            px_q <= px_nxt;
            if (wrap)
               gap_q <= GAP_MIN + {2'b00, lfsr_out};
         end
      end
   end

   assign ground    = (by11 >= V_VIS_END);
   assign collide   = (|hit) || ground;
   // a colliding tick freezes everything, so it never scrolls or scores
   assign scroll    = (state == RUN) && !collide;
   assign pipe_fill = |fill;
   assign score_sum = {1'b0, score} + {8'd0, pass[0]} + {8'd0, pass[1]};

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (up) state_nxt = RUN;
         RUN:     if (collide) state_nxt = DEAD;
         default: state_nxt = state;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         game_over <= 1'b0;
         score     <= 8'd0;
      end else begin
         state     <= state_nxt;
         game_over <= (state_nxt == DEAD);
         if (scroll)
            score <= score_sum[8] ? 8'hFF : score_sum[7:0];
      end
   end

endmodule

// File: tb/tb_pipe_controller.sv
// tb/tb_pipe_controller.sv - bench for pipe_controller: game model plus directed literal checks
`timescale 1ns/1ps
module tb_pipe_controller;

   logic       clk = 1'b0;
   logic       rst, up;
   logic [9:0] bird_y, hCount, vCount;
   logic       pipe_fill, game_over;
   logic [7:0] score;

   pipe_controller dut (
      .clk       (clk),
      .rst       (rst),
      .up        (up),
      .bird_y    (bird_y),
      .hCount    (hCount),
      .vCount    (vCount),
      .pipe_fill (pipe_fill),
      .game_over (game_over),
      .score     (score)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // game model: pipe positions in plain integers, state 0 idle / 1 run / 2 dead
   int         m_px [2];
   int         m_gap [2];
   int         m_score, m_state, passed;
   bit         crash, track;
   logic [7:0] m_lfsr;

   typedef struct {
      string name;
      int    h;
      int    v;
      int    fill;
      int    sc;
      int    go;
   } pin_t;
   pin_t pins [$];

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_px[0] = 784;  m_px[1] = 1124;
      m_gap[0] = 200; m_gap[1] = 150;
      m_score = 0;
      m_state = 0;
      m_lfsr = 8'hA5;
   endtask

   function automatic int model_fill(int h, int v);
      for (int i = 0; i < 2; i++)
         if (h >= m_px[i] && h < m_px[i] + 40 && v >= 35 && v <= 514 &&
             (v < m_gap[i] || v >= m_gap[i] + 120))
            return 1;
      return 0;
   endfunction

   function automatic int target_y();
      int best;
      best = -1;
      for (int i = 0; i < 2; i++)
         if (m_px[i] + 39 >= 445 && (best < 0 || m_px[i] < m_px[best]))
            best = i;
      return m_gap[best] + 60;
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         crash = (int'(bird_y) >= 514);
         for (int i = 0; i < 2; i++)
            if (m_px[i] <= 455 && m_px[i] + 39 >= 445 &&
                (int'(bird_y) - 5 < m_gap[i] || int'(bird_y) + 5 >= m_gap[i] + 120))
               crash = 1'b1;
         if (m_state == 0) begin
            if (up) m_state = 1;
         end else if (m_state == 1) begin
            if (crash) m_state = 2;
            else begin
               passed = 0;
               for (int i = 0; i < 2; i++) begin
                  if (m_px[i] <= 104) begin
                     m_px[i] = m_px[i] + 678;
                     m_gap[i] = 75 + int'(m_lfsr);
                  end else begin
                     m_px[i] = m_px[i] - 2;
                     if (m_px[i] + 41 >= 445 && m_px[i] + 39 < 445) passed++;
                  end
               end
               m_score = (m_score + passed > 255) ? 255 : m_score + passed;
            end
         end
         m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      end
   end

   task automatic probe(string name, int h, int v);
      if (h >= 0 && h < 1024 && v >= 0 && v < 1024) begin
         hCount = h[9:0];
         vCount = v[9:0];
         #0.2;
         check(name, int'(pipe_fill), model_fill(h, v));
      end
   endtask

   // single compare process: model vs DUT every cycle, then any queued literal pins
   initial begin
      pin_t p;
      hCount = '0;
      vCount = '0;
      forever begin
         @(negedge clk);
         check("score", int'(score), m_score);
         check("game_over", int'(game_over), int'(m_state == 2));
         for (int i = 0; i < 2; i++) begin
            probe("fill_left_top",  m_px[i],      m_gap[i] - 1);
            probe("fill_before",    m_px[i] - 1,  m_gap[i] - 1);
            probe("fill_right_bot", m_px[i] + 39, m_gap[i] + 120);
            probe("fill_after",     m_px[i] + 40, m_gap[i] + 120);
            probe("fill_gap_low",   m_px[i] + 20, m_gap[i] + 119);
            probe("fill_gap_top",   m_px[i] + 20, m_gap[i]);
            probe("fill_v34",       m_px[i] + 5,  34);
            probe("fill_v35",       m_px[i] + 5,  35);
            probe("fill_v514",      m_px[i] + 5,  514);
            probe("fill_v515",      m_px[i] + 5,  515);
         end
         while (pins.size() > 0) begin
            p = pins.pop_front();
            if (p.h >= 0) begin
               hCount = p.h[9:0];
               vCount = p.v[9:0];
               #0.2;
               check(p.name, int'(pipe_fill), p.fill);
            end
            if (p.sc >= 0) check(p.name, int'(score), p.sc);
            if (p.go >= 0) check(p.name, int'(game_over), p.go);
         end
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (track) bird_y = target_y()[9:0];
      end
   endtask

   task automatic pin(string name, int h, int v, int fill, int sc, int go);
      pin_t p;
      p.name = name; p.h = h; p.v = v; p.fill = fill; p.sc = sc; p.go = go;
      pins.push_back(p);
   endtask

   initial begin
      rst = 1'b1;
      up = 1'b0;
      bird_y = 10'd300;
      track = 1'b0;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      // reset and idle
      pin("reset_fill_top", 790, 100, 1, 0, 0);
      pin("reset_fill_gap", 790, 250, 0, -1, -1);
      tick(20);
      pin("idle_fill_top", 790, 100, 1, 0, 0);
      pin("idle_fill_gap", 790, 250, 0, -1, -1);
      pin("idle_gap_bottom", 790, 320, 1, -1, -1);
      pin("idle_gap_last", 790, 319, 0, -1, -1);

      // run with the bird tracking the approaching gap
      up = 1'b1;
      tick(1);
      up = 1'b0;
      track = 1'b1;
      bird_y = target_y()[9:0];
      tick(189);
      pin("score_at_406", -1, 0, -1, 0, 0);
      tick(1);
      pin("score_at_404", -1, 0, -1, 1, 0);
      tick(150);
      pin("px0_at_104", 104, 100, 1, 1, 0);
      pin("px0_left_104", 103, 100, 0, -1, -1);
      tick(1);
      pin("px0_wrap_782", 782, 40, 1, -1, 0);
      pin("px0_wrap_left", 781, 40, 0, -1, -1);
      tick(19);
      pin("score_two", -1, 0, -1, 2, 0);
      tick(5);

      // restart and crash into pipe 0 above its gap
      @(posedge clk);
      #3 rst = 1'b1;
      model_reset();
      track = 1'b0;
      pin("rst_run_fill", 790, 100, 1, 0, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      bird_y = 10'd260;
      up = 1'b1;
      tick(1);
      up = 1'b0;
      tick(165);
      bird_y = 10'd100;
      pin("pre_hit", 454, 100, 1, 0, 0);
      tick(1);
      pin("hit_dead", 454, 100, 1, 0, 1);
      pin("hit_left", 453, 100, 0, -1, -1);
      tick(50);
      pin("dead_frozen", 454, 100, 1, 0, 1);
      pin("dead_frozen_left", 453, 100, 0, -1, -1);

      // asynchronous reset out of DEAD, then restart from 784
      @(posedge clk);
      #4 rst = 1'b1;
      model_reset();
      pin("dead_rst_fill", 790, 100, 1, 0, 0);
      pin("dead_rst_left", 783, 100, 0, -1, -1);
      @(posedge clk);
      #1 rst = 1'b0;
      bird_y = 10'd300;
      up = 1'b1;
      tick(1);
      up = 1'b0;
      pin("restart_784", 784, 100, 1, 0, 0);
      tick(1);
      pin("restart_782", 782, 100, 1, -1, 0);
      pin("restart_821", 821, 100, 1, -1, -1);
      pin("restart_822", 822, 100, 0, -1, -1);

      // ground boundary
      bird_y = 10'd513;
      tick(1);
      pin("ground_513", -1, 0, -1, -1, 0);
      bird_y = 10'd514;
      tick(1);
      pin("ground_514", -1, 0, -1, -1, 1);
      tick(3);

      @(negedge clk);
      #5;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
